// File: rtl/dac_out_pkg.sv
// Shared definitions for the DAC output stage and its neighbours.
//   SAMPLE_W   : default voice sample width, shared with the voice output mux
//   dac_mode_e : modulation mode select (PWM / first-order sigma-delta)
package dac_out_pkg;

  localparam int SAMPLE_W = 12;

  typedef enum logic {
    MODE_PWM = 1'b0,
    MODE_SD  = 1'b1
  } dac_mode_e;

endpackage

// File: rtl/dac_out_stage_tick_div.sv
// tick_div: clock-enable divider, one tick every div+1 clocks while enabled.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : enable; low parks the counter at all ones
//   div        : divide setting (tick period = div+1 clocks)
//   tick       : single-cycle clock enable
// The counter parks at all ones, so the first enabled clock always ticks.
// Comparing with >= lets a lowered div take effect on the very next clock
// instead of waiting for the counter to roll over.
module tick_div #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

  assign tick = en && (div_cnt_q >= div);

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!en)       div_cnt_d = '1;
    else if (tick) div_cnt_d = '0;
    else           div_cnt_d = div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_cnt_q <= '1;
    else        div_cnt_q <= div_cnt_d;
  end

endmodule

// File: rtl/dac_out_stage.sv
// dac_out_stage: converts an M-bit unsigned voice sample into a 1-bit DAC
// stream, either fixed-period PWM or first-order sigma-delta.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   en         : stage enable; low forces idle (output 0, counters parked)
//   mode       : 0 = PWM, 1 = sigma-delta (applies from the next tick)
//   div        : tick every div+1 clocks
//   sample_in  : unsigned sample from the voice mux
//   sample_req : one-clock pulse after sample_in was latched
//   dac_out    : registered 1-bit DAC output
// A new sample is latched once per 2^M ticks, at the period wrap. All
// outputs come straight from flops.
module dac_out_stage
  import dac_out_pkg::*;
#(
  parameter int M     = SAMPLE_W,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [DIV_W-1:0] div,
  input  logic [M-1:0]     sample_in,
  output logic             sample_req,
  output logic             dac_out
);

  logic         tick;
  logic [M-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [M-1:0] sample_q, sample_d;
  logic [M-1:0] acc_q, acc_d;
  logic         dac_q, dac_d;
  logic         req_q, req_d;

  logic         wrap;
  logic [M-1:0] s_sel;
  logic [M-1:0] pwm_next;
  logic [M:0]   sd_sum;

  tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .tick  (tick)
  );

  // At the wrap tick the fresh sample is used immediately, so slot 0 of
  // a period already reflects the value being latched.
  assign wrap     = (pwm_cnt_q == '1);
  assign s_sel    = wrap ? sample_in : sample_q;
  assign pwm_next = pwm_cnt_q + 1'b1;
  assign sd_sum   = {1'b0, acc_q} + {1'b0, s_sel};

  always_comb begin
    pwm_cnt_d = pwm_cnt_q;
    sample_d  = sample_q;
    acc_d     = acc_q;
    dac_d     = dac_q;
    req_d     = 1'b0;
    if (!en) begin
      // Parking pwm_cnt at all ones makes the first enabled tick a wrap.
      pwm_cnt_d = '1;
      acc_d     = '0;
      dac_d     = 1'b0;
    end else if (tick) begin
      pwm_cnt_d = pwm_next;
      req_d     = wrap;
      if (wrap) sample_d = sample_in;
      if (mode == MODE_SD) begin
        dac_d = sd_sum[M];
        acc_d = sd_sum[M-1:0];
      end else begin
        dac_d = (pwm_next < s_sel);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '1;
      sample_q  <= '0;
      acc_q     <= '0;
      dac_q     <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      sample_q  <= sample_d;
      acc_q     <= acc_d;
      dac_q     <= dac_d;
      req_q     <= req_d;
    end
  end

  assign dac_out    = dac_q;
  assign sample_req = req_q;

endmodule

// File: tb/tb_dac_out_stage.sv
module tb_dac_out_stage;
  import dac_out_pkg::*;

  localparam int M     = 4;
  localparam int DIV_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic [DIV_W-1:0] div = '0;
  logic [M-1:0]     sample_in = '0;
  logic             sample_req;
  logic             dac_out;

  int n_checks = 0;
  int n_fail   = 0;

  dac_out_stage #(.M(M), .DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .mode       (mode),
    .div        (div),
    .sample_in  (sample_in),
    .sample_req (sample_req),
    .dac_out    (dac_out)
  );

  always #5 clk = ~clk;

  // one active edge, then settle 1ns for sampling / driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    en = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = MODE_PWM; div = 0; sample_in = 4'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if ({dac_out, sample_req} !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_hold cyc=%0d: dac=%b req=%b want 0 0", i, dac_out, sample_req);
      end
    end
    #2 rst_n = 1'b1;
    step();
    n_checks++;
    if (sample_req !== 1'b1 || dac_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_latch: req=%b dac=%b want 1 1", sample_req, dac_out);
    end
    step();
    n_checks++;
    if (sample_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_req_drop: req=%b want 0", sample_req);
    end
    // mid-period async reset
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (dac_out !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_async_reset dac: got %b want 1", dac_out);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dac_out, sample_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset_immediate: dac=%b req=%b want 0 0", dac_out, sample_req);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (sample_req !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset_relatch: req=%b want 1", sample_req);
    end
  endtask

  task automatic test_pwm();
    int ones;
    logic exp_dac, exp_req;
    go_idle();
    mode = MODE_PWM; div = 0; sample_in = 4'd5; en = 1'b1;
    ones = 0;
    for (int e = 0; e < 32; e++) begin
      step();
      exp_dac = ((e % 16) < 5);
      exp_req = ((e % 16) == 0);
      if (e < 16 && dac_out === 1'b1) ones++;
      n_checks++;
      if (dac_out !== exp_dac || sample_req !== exp_req) begin
        n_fail++;
        $display("FAIL pwm5 slot=%0d: dac=%b req=%b want %b %b", e % 16, dac_out, sample_req, exp_dac, exp_req);
      end
    end
    n_checks++;
    if (ones != 5) begin
      n_fail++;
      $display("FAIL pwm5_ones: got %0d want 5", ones);
    end
  endtask

  task automatic test_sd();
    logic [M-1:0] svals [3] = '{4'd4, 4'd0, 4'd15};
    int           want_ones [3] = '{4, 0, 15};
    int ones;
    logic exp_dac;
    for (int k = 0; k < 3; k++) begin
      go_idle();
      mode = MODE_SD; div = 0; sample_in = svals[k]; en = 1'b1;
      ones = 0;
      for (int e = 0; e < 16; e++) begin
        step();
        if (dac_out === 1'b1) ones++;
        if (k == 0)      exp_dac = ((e % 4) == 3);
        else if (k == 1) exp_dac = 1'b0;
        else             exp_dac = (e != 0);
        n_checks++;
        if (dac_out !== exp_dac) begin
          n_fail++;
          $display("FAIL sd s=%0d tick=%0d: dac=%b want %b", svals[k], e, dac_out, exp_dac);
        end
      end
      n_checks++;
      if (ones != want_ones[k]) begin
        n_fail++;
        $display("FAIL sd_ones s=%0d: got %0d want %0d", svals[k], ones, want_ones[k]);
      end
    end
  endtask

  task automatic test_divider();
    logic exp_dac, exp_req;
    go_idle();
    mode = MODE_PWM; div = 4'd2; sample_in = 4'd8; en = 1'b1;
    for (int e = 0; e < 60; e++) begin
      step();
      exp_dac = (((e / 3) % 16) < 8);
      exp_req = ((e % 48) == 0);
      n_checks++;
      if (dac_out !== exp_dac || sample_req !== exp_req) begin
        n_fail++;
        $display("FAIL div2 clk=%0d: dac=%b req=%b want %b %b", e, dac_out, sample_req, exp_dac, exp_req);
      end
    end
  endtask

  task automatic test_div_change();
    go_idle();
    mode = MODE_PWM; div = 4'd2; sample_in = 4'd8; en = 1'b1;
    // 22 edges reach slot 7; one more leaves div_cnt at 1
    for (int e = 0; e < 23; e++) step();
    n_checks++;
    if (dac_out !== 1'b1) begin
      n_fail++;
      $display("FAIL div_change_pre: dac=%b want 1", dac_out);
    end
    div = 4'd0;
    for (int k = 8; k < 16; k++) begin
      step();
      n_checks++;
      if (dac_out !== 1'b0 || sample_req !== 1'b0) begin
        n_fail++;
        $display("FAIL div_change slot=%0d: dac=%b req=%b want 0 0", k, dac_out, sample_req);
      end
    end
    step();
    n_checks++;
    if (dac_out !== 1'b1 || sample_req !== 1'b1) begin
      n_fail++;
      $display("FAIL div_change_wrap: dac=%b req=%b want 1 1", dac_out, sample_req);
    end
  endtask

  task automatic test_mid_change();
    int ones0, ones1;
    go_idle();
    mode = MODE_PWM; div = 0; sample_in = 4'd3; en = 1'b1;
    ones0 = 0; ones1 = 0;
    for (int e = 0; e < 32; e++) begin
      if (e == 6) sample_in = 4'd12;
      step();
      if (dac_out === 1'b1) begin
        if (e < 16) ones0++;
        else        ones1++;
      end
      if (e == 16) begin
        n_checks++;
        if (sample_req !== 1'b1) begin
          n_fail++;
          $display("FAIL mid_change_req: req=%b want 1", sample_req);
        end
      end
    end
    n_checks++;
    if (ones0 != 3) begin
      n_fail++;
      $display("FAIL mid_change_cur_period: ones=%0d want 3", ones0);
    end
    n_checks++;
    if (ones1 != 12) begin
      n_fail++;
      $display("FAIL mid_change_next_period: ones=%0d want 12", ones1);
    end
  endtask

  task automatic test_en_toggle();
    logic exp_dac;
    // PWM: output drops at once, restart from slot 0
    go_idle();
    mode = MODE_PWM; div = 0; sample_in = 4'd5; en = 1'b1;
    for (int e = 0; e < 3; e++) step();
    en = 1'b0;
    step();
    n_checks++;
    if (dac_out !== 1'b0 || sample_req !== 1'b0) begin
      n_fail++;
      $display("FAIL en_drop: dac=%b req=%b want 0 0", dac_out, sample_req);
    end
    en = 1'b1;
    step();
    n_checks++;
    if (dac_out !== 1'b1 || sample_req !== 1'b1) begin
      n_fail++;
      $display("FAIL en_raise_latch: dac=%b req=%b want 1 1", dac_out, sample_req);
    end
    for (int s = 1; s < 16; s++) begin
      step();
      exp_dac = (s < 5);
      n_checks++;
      if (dac_out !== exp_dac || sample_req !== 1'b0) begin
        n_fail++;
        $display("FAIL en_restart slot=%0d: dac=%b req=%b want %b 0", s, dac_out, sample_req, exp_dac);
      end
    end
    // SD: accumulator must restart from zero
    go_idle();
    mode = MODE_SD; sample_in = 4'd4; en = 1'b1;
    for (int e = 0; e < 3; e++) step();
    en = 1'b0;
    step();
    en = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      exp_dac = (e == 3);
      n_checks++;
      if (dac_out !== exp_dac || sample_req !== (e == 0)) begin
        n_fail++;
        $display("FAIL en_sd_acc_clear tick=%0d: dac=%b req=%b want %b %b", e, dac_out, sample_req, exp_dac, (e == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pwm();
    test_sd();
    test_divider();
    test_div_change();
    test_mid_change();
    test_en_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
